// File: rtl/hex_pkg.sv
// Shared definitions for the hex display bus: sequencer states and the
// slave register map, so sequencer and display slaves agree on addresses.
package hex_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_COMMIT,
    ST_GAP,
    ST_DONE
  } seq_state_t;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_COMMIT = 2'd1;

  localparam logic       IDLE_WRITE_N = 1'b1;
  localparam logic [1:0] IDLE_ADDRESS = ADDR_DATA;
  localparam logic [7:0] IDLE_DATA    = 8'h00;

  function automatic logic [7:0] dataByte(input logic [3:0] nibble);
    return {4'h0, nibble};
  endfunction

endpackage

// File: rtl/hex_bus_sequencer.sv
// Streams a captured multi-digit hex value to a row of display slaves,
// one WRITE phase then one COMMIT phase per digit, lowest digit first.
import hex_pkg::*;

module hex_bus_sequencer #(
  parameter int NUM_DIGITS  = 4,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                    iClk,
  input  logic                    iReset,
  input  logic [4*NUM_DIGITS-1:0] iValue,
  input  logic                    iValid,
  output logic                    oReady,
  output logic [NUM_DIGITS-1:0]   oChip_select_n,
  output logic                    oWrite_n,
  output logic [1:0]              oAddress,
  output logic [7:0]              oHex_Data,
  output logic                    oBusy,
  output logic                    oDone
);

  localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYCLES - 1);
  localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

  seq_state_t              r_state;
  logic [2:0]              r_digit;
  logic [3:0]              r_holdCnt;
  logic [4*NUM_DIGITS-1:0] r_value;

  seq_state_t              w_nextState;
  logic [2:0]              w_nextDigit;
  logic [3:0]              w_nextHold;
  logic [4*NUM_DIGITS-1:0] w_nextValue;
  logic                    w_holdDone;
  logic [3:0]              w_nextNibble;
  logic [NUM_DIGITS-1:0]   w_nextSelect;

  assign w_holdDone = (r_holdCnt == HOLD_LAST);

  always_comb begin
    w_nextState = r_state;
    w_nextDigit = r_digit;
    w_nextHold  = r_holdCnt;
    w_nextValue = r_value;
    case (r_state)
      ST_IDLE: begin
        w_nextDigit = '0;
        w_nextHold  = '0;
        if (iValid) begin
          w_nextState = ST_WRITE;
          w_nextValue = iValue;
        end
      end
      ST_WRITE: begin
        if (w_holdDone) begin
          w_nextState = ST_COMMIT;
          w_nextHold  = '0;
        end else begin
          w_nextHold = r_holdCnt + 4'd1;
        end
      end
      ST_COMMIT: begin
        if (w_holdDone) begin
          w_nextHold  = '0;
          w_nextState = (r_digit == LAST_DIGIT) ? ST_DONE : ST_GAP;
        end else begin
          w_nextHold = r_holdCnt + 4'd1;
        end
      end
      ST_GAP: begin
        w_nextState = ST_WRITE;
        w_nextDigit = r_digit + 3'd1;
      end
      ST_DONE: begin
        w_nextState = ST_IDLE;
        w_nextDigit = '0;
      end
      default: begin
        w_nextState = ST_IDLE;
        w_nextDigit = '0;
        w_nextHold  = '0;
      end
    endcase
  end

  // Bus outputs are decoded from the next state so they line up with the state they belong to.
  assign w_nextNibble = w_nextValue[4*int'(w_nextDigit) +: 4];
  assign w_nextSelect = ~(NUM_DIGITS'(1) << w_nextDigit);

  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_state        <= ST_IDLE;
      r_digit        <= '0;
      r_holdCnt      <= '0;
      r_value        <= '0;
      oReady         <= 1'b1;
      oBusy          <= 1'b0;
      oDone          <= 1'b0;
      oChip_select_n <= '1;
      oWrite_n       <= IDLE_WRITE_N;
      oAddress       <= IDLE_ADDRESS;
      oHex_Data      <= IDLE_DATA;
    end else begin
      r_state   <= w_nextState;
      r_digit   <= w_nextDigit;
      r_holdCnt <= w_nextHold;
      r_value   <= w_nextValue;
      oReady    <= (w_nextState == ST_IDLE);
      oBusy     <= (w_nextState != ST_IDLE);
      oDone     <= (w_nextState == ST_DONE);
      case (w_nextState)
        ST_WRITE: begin
          oChip_select_n <= w_nextSelect;
          oWrite_n       <= 1'b0;
          oAddress       <= ADDR_DATA;
          oHex_Data      <= dataByte(w_nextNibble);
        end
        ST_COMMIT: begin
          oChip_select_n <= w_nextSelect;
          oWrite_n       <= 1'b1;
          oAddress       <= ADDR_COMMIT;
          oHex_Data      <= IDLE_DATA;
        end
        default: begin
          oChip_select_n <= '1;
          oWrite_n       <= IDLE_WRITE_N;
          oAddress       <= IDLE_ADDRESS;
          oHex_Data      <= IDLE_DATA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_bus_sequencer.sv
// Bench for hex_bus_sequencer: a per-cycle bus scoreboard on two instances
// (hold 1 and hold 3) plus a behavioural display slave on the hold-1 bus.
module tb_hex_bus_sequencer;

  typedef struct packed {
    logic [3:0] cs;
    logic       wrn;
    logic [1:0] addr;
    logic [7:0] data;
    logic       ready;
    logic       busy;
    logic       done;
  } busWord_t;

  localparam busWord_t IDLE_WORD = '{cs: 4'hF, wrn: 1'b1, addr: 2'd0, data: 8'h00,
                                     ready: 1'b1, busy: 1'b0, done: 1'b0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] valA = '0, valB = '0;
  logic        validA = 1'b0, validB = 1'b0;
  logic        readyA, wrnA, busyA, doneA;
  logic        readyB, wrnB, busyB, doneB;
  logic [3:0]  csA, csB;
  logic [1:0]  addrA, addrB;
  logic [7:0]  dataA, dataB;

  busWord_t qA[$];
  busWord_t qB[$];
  busWord_t obsA, obsB;
  int checks = 0;
  int errors = 0;
  int selA[4];
  logic [3:0] prevCsA = 4'hF;
  logic [3:0] pendA[4];
  logic [3:0] shownA[4];

  always #5 clk = ~clk;

  hex_bus_sequencer #(.NUM_DIGITS(4), .HOLD_CYCLES(1)) dutA (
    .iClk(clk), .iReset(reset), .iValue(valA), .iValid(validA), .oReady(readyA),
    .oChip_select_n(csA), .oWrite_n(wrnA), .oAddress(addrA), .oHex_Data(dataA),
    .oBusy(busyA), .oDone(doneA)
  );

  hex_bus_sequencer #(.NUM_DIGITS(4), .HOLD_CYCLES(3)) dutB (
    .iClk(clk), .iReset(reset), .iValue(valB), .iValid(validB), .oReady(readyB),
    .oChip_select_n(csB), .oWrite_n(wrnB), .oAddress(addrB), .oHex_Data(dataB),
    .oBusy(busyB), .oDone(doneB)
  );

  assign obsA = {csA, wrnA, addrA, dataA, readyA, busyA, doneA};
  assign obsB = {csB, wrnB, addrB, dataB, readyB, busyB, doneB};

  // Expected bus word for cycle k after acceptance, from the phase timing alone.
  function automatic busWord_t expWord(input logic [15:0] v, input int h, input int k);
    int p, doneCycle, j, dig, r;
    busWord_t w;
    p = 2*h + 1;
    doneCycle = 2*h*4 + 4;
    w = '{cs: 4'hF, wrn: 1'b1, addr: 2'd0, data: 8'h00, ready: 1'b0, busy: 1'b1, done: 1'b0};
    if (k > doneCycle) begin
      w = IDLE_WORD;
    end else if (k == doneCycle) begin
      w.done = 1'b1;
    end else begin
      j = k - 1;
      dig = j / p;
      r = j % p;
      if (r < 2*h) begin
        w.cs = 4'hF & ~(4'b0001 << dig);
        if (r < h) begin
          w.wrn = 1'b0;
          w.data = {4'h0, v[dig*4 +: 4]};
        end else begin
          w.addr = 2'd1;
        end
      end
    end
    return w;
  endfunction

  function automatic string fmt(input busWord_t w);
    return $sformatf("cs=%h wr_n=%b addr=%0d data=%h rdy=%b busy=%b done=%b",
                     w.cs, w.wrn, w.addr, w.data, w.ready, w.busy, w.done);
  endfunction

  function automatic logic [6:0] segOf(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Scoreboard for instance A; also counts how often each select is entered.
  always @(negedge clk) begin : monA
    busWord_t expW;
    for (int d = 0; d < 4; d++)
      if (prevCsA[d] === 1'b1 && csA[d] === 1'b0) selA[d]++;
    prevCsA = csA;
    if (qA.size() > 0) begin
      expW = qA.pop_front();
      checks++;
      if (obsA !== expW) begin
        errors++;
        $display("[TB] FAIL busA: got %s, expected %s", fmt(obsA), fmt(expW));
      end
    end
  end

  always @(negedge clk) begin : monB
    busWord_t expW;
    if (qB.size() > 0) begin
      expW = qB.pop_front();
      checks++;
      if (obsB !== expW) begin
        errors++;
        $display("[TB] FAIL busB: got %s, expected %s", fmt(obsB), fmt(expW));
      end
    end
  end

  // Behavioural display slave: latch on a data write, show on commit.
  always @(posedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (csA[d] === 1'b0) begin
        if (wrnA === 1'b0 && addrA === 2'd0) pendA[d] <= dataA[3:0];
        else if (addrA === 2'd1) shownA[d] <= pendA[d];
      end
    end
  end

  task automatic accept(input bit slow, input logic [15:0] v, output int waited);
    bit ok;
    int h, doneCycle;
    ok = 1'b0;
    h = slow ? 3 : 1;
    doneCycle = 2*h*4 + 4;
    waited = 0;
    if (slow) begin validB = 1'b1; valB = v; end
    else begin validA = 1'b1; valA = v; end
    while (!ok && waited < 100) begin
      @(negedge clk);
      waited++;
      ok = slow ? (readyB === 1'b1) : (readyA === 1'b1);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: ready=0 after %0d cycles, required 1", waited);
    end else begin
      @(posedge clk);
      for (int k = 1; k <= doneCycle + 1; k++)
        if (slow) qB.push_back(expWord(v, h, k));
        else qA.push_back(expWord(v, h, k));
    end
    #2;
    if (slow) validB = 1'b0;
    else validA = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((qA.size() != 0 || qB.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (qA.size() != 0 || qB.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d/%0d entries left, required 0", qA.size(), qB.size());
      qA.delete();
      qB.delete();
    end
    @(posedge clk);
    #2;
  endtask

  task automatic clearSel();
    for (int d = 0; d < 4; d++) selA[d] = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    validA = 1'b1; valA = 16'hAAAA;
    validB = 1'b1; valB = 16'h5555;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obsA !== IDLE_WORD) begin
      errors++;
      $display("[TB] FAIL reset_state_A: got %s, expected %s", fmt(obsA), fmt(IDLE_WORD));
    end
    checks++;
    if (obsB !== IDLE_WORD) begin
      errors++;
      $display("[TB] FAIL reset_state_B: got %s, expected %s", fmt(obsB), fmt(IDLE_WORD));
    end
    @(posedge clk);
    #2;
    reset = 1'b0; validA = 1'b0; validB = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busyA !== 1'b0 || busyB !== 1'b0 || readyA !== 1'b1 || readyB !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_no_capture: busy=%b/%b ready=%b/%b, required busy 0 ready 1",
               busyA, busyB, readyA, readyB);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_basic();
    int w;
    clearSel();
    accept(1'b0, 16'h1A3F, w);
    waitDrain();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (selA[d] !== 1) begin
        errors++;
        $display("[TB] FAIL select_once[%0d]: entered %0d times, required 1", d, selA[d]);
      end
    end
  endtask

  task automatic test_hold3();
    int w;
    accept(1'b1, 16'hC0DE, w);
    waitDrain();
  endtask

  task automatic test_ignore_busy();
    int w;
    accept(1'b0, 16'h0000, w);
    validA = 1'b1;
    valA = 16'hFFFF;
    repeat (12) @(posedge clk);
    #2;
    validA = 1'b0;
    waitDrain();
    repeat (2) @(negedge clk);
    checks++;
    if (busyA !== 1'b0 || readyA !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ignored_value: busy=%b ready=%b, required busy 0 ready 1", busyA, readyA);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_back_to_back();
    int w;
    accept(1'b0, 16'h1234, w);
    accept(1'b0, 16'h5678, w);
    checks++;
    if (w !== 13) begin
      errors++;
      $display("[TB] FAIL restart_latency: second accept after %0d cycles, required 13", w);
    end
    waitDrain();
  endtask

  task automatic test_reset_mid();
    int w;
    clearSel();
    accept(1'b0, 16'h9876, w);
    repeat (5) @(posedge clk);
    #2;
    while (qA.size() > 1) void'(qA.pop_back());
    qA.push_back(IDLE_WORD);
    qA.push_back(IDLE_WORD);
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    waitDrain();
    repeat (10) @(posedge clk);
    #2;
    checks++;
    if (selA[0] !== 1 || selA[1] !== 1 || selA[2] !== 0 || selA[3] !== 0) begin
      errors++;
      $display("[TB] FAIL reset_abandon: selects entered %0d %0d %0d %0d, required 1 1 0 0",
               selA[0], selA[1], selA[2], selA[3]);
    end
  endtask

  task automatic test_slave();
    int w;
    logic [6:0] expSeg[4];
    expSeg[0] = 7'h71;
    expSeg[1] = 7'h79;
    expSeg[2] = 7'h79;
    expSeg[3] = 7'h7C;
    accept(1'b0, 16'hBEEF, w);
    waitDrain();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (segOf(shownA[d]) !== expSeg[d]) begin
        errors++;
        $display("[TB] FAIL slave_digit[%0d]: segments %h, required %h", d, segOf(shownA[d]), expSeg[d]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearSel();
    test_reset();
    test_basic();
    test_hold3();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_slave();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_bus_sequencer.md
HEX_BUS_SEQUENCER -- requirements
Module: hex_bus_sequencer

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of display slaves driven, one chip-select each, range 1..8.
REQ-002 SHALL have parameter HOLD_CYCLES, default 1: cycles each bus phase is held, range 1..15.
REQ-003 SHALL have port iClk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port iReset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port iValue, input, 4*NUM_DIGITS: value to display; nibble d goes to digit d.
REQ-006 SHALL have port iValid, input, 1: iValue is presented.
REQ-007 SHALL have port oReady, output, 1: block accepts a new value this cycle.
REQ-008 SHALL have port oChip_select_n, output, NUM_DIGITS: active-low select, one per display slave.
REQ-009 SHALL have port oWrite_n, output, 1: active-low write strobe, shared by all slaves.
REQ-010 SHALL have port oAddress, output, 2: slave register address, shared.
REQ-011 SHALL have port oHex_Data, output, 8: write data, shared.
REQ-012 SHALL have port oBusy, output, 1: high from the cycle after acceptance through the DONE cycle.
REQ-013 SHALL have port oDone, output, 1: one-cycle pulse when the last digit is committed.

Function
REQ-014 SHALL accept a value on a rising edge where iValid=1 and oReady=1, and capture iValue into an internal register on that edge.
REQ-015 SHALL assert oReady only in state IDLE, and SHALL ignore iValid in every other state.
REQ-016 SHALL implement states IDLE, WRITE, COMMIT, GAP and DONE.
REQ-017 SHALL transition IDLE->WRITE on acceptance.
REQ-018 SHALL transition WRITE->COMMIT after HOLD_CYCLES cycles.
REQ-019 SHALL transition COMMIT->GAP after HOLD_CYCLES cycles when the digit index < NUM_DIGITS-1.
REQ-020 SHALL transition COMMIT->DONE after HOLD_CYCLES cycles when the digit index = NUM_DIGITS-1.
REQ-021 SHALL hold GAP for exactly 1 cycle, increment the digit index and return to WRITE.
REQ-022 SHALL hold DONE for exactly 1 cycle and then return to IDLE.
REQ-023 SHALL, in WRITE for digit d, drive oChip_select_n[d]=0 with all other selects 1, oWrite_n=0, oAddress=0 and oHex_Data={4'h0, captured nibble d}.
REQ-024 SHALL, in COMMIT for digit d, drive oChip_select_n[d]=0, oWrite_n=1, oAddress=1 and oHex_Data=0.
REQ-025 SHALL, in IDLE, GAP and DONE, drive oChip_select_n all 1, oWrite_n=1, oAddress=0 and oHex_Data=0.
REQ-026 SHALL drive all bus outputs from registers, with no combinational path from iValid or iValue to any output.
REQ-027 SHALL process digits in ascending order starting at 0; the digit index SHALL wrap to 0 on return to IDLE.
REQ-028 SHALL assert oDone in the DONE cycle only.
REQ-029 SHALL place the DONE cycle at 2*HOLD_CYCLES*NUM_DIGITS + (NUM_DIGITS-1) + 1 cycles after the acceptance edge (12 cycles for the defaults).
REQ-030 SHALL assert oReady again on the cycle after DONE; a value presented that cycle SHALL be accepted with no dead cycle.
REQ-031 SHALL NOT allow a change of iValue during a transfer to affect the digits in flight.
REQ-032 SHALL NOT select any slave for more than one WRITE phase and one COMMIT phase per transfer.

Reset
REQ-033 SHALL, when iReset=1 at a rising edge, force state IDLE, digit index 0, hold counter 0 and captured value 0.
REQ-034 SHALL, under reset, force oReady=1, oBusy=0, oDone=0, oChip_select_n all 1, oWrite_n=1, oAddress=0 and oHex_Data=0.
REQ-035 SHALL, on reset mid-transfer, abandon the transfer at the next edge with no further bus phase; already-committed digits keep their values.
REQ-036 SHALL give iReset priority over acceptance in the same cycle; a value presented during reset is not captured.

Structure
REQ-037 SHALL take from shared package hex_pkg: the state enumeration, ADDR_DATA=2'd0, ADDR_COMMIT=2'd1 and the idle bus constants, so that the display slaves use the same address map.
REQ-038 SHALL be implemented as a single module (FSM, hold counter, digit index, capture register) with no sub-module.

Verification
REQ-039 SHALL be verified with defaults and iValue=16'h1A3F accepted: WRITE phases carry data 0x0F, 0x03, 0x0A, 0x01 on selects 0..3, each followed by a COMMIT at address 1; oDone=1 twelve cycles after acceptance.
REQ-040 SHALL be verified with HOLD_CYCLES=3: each WRITE and COMMIT phase lasts exactly 3 cycles; oDone arrives 28 cycles after acceptance.
REQ-041 SHALL be verified by asserting iValid=1 with iValue=16'hFFFF during a busy transfer of 16'h0000: it is ignored, only 0x00 is written, and oReady is 0 throughout.
REQ-042 SHALL be verified back-to-back: 16'h1234 is accepted, then 16'h5678 is held valid; the second is accepted on the cycle after DONE and the sequences do not overlap.
REQ-043 SHALL be verified by asserting iReset during the COMMIT of digit 1: all selects are 1 at the next edge, digits 2 and 3 are never selected, and oReady=1.
REQ-044 SHALL be verified with an instance of the display slave on each select: after 16'hBEEF the slave outputs decode b, E, E, F.
